// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encodings, default widths and control-word strobe positions
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SAM_ADDR_W   = 12;
    localparam int SAM_DATA_W   = 16;
    localparam int SAM_CW_W     = 22;
    localparam int CW_MEM_RD    = 20;
    localparam int CW_MEM_WR    = 21;
    localparam int CNT_W        = 4;

    function automatic logic cw_mem_rd(input logic [SAM_CW_W-1:0] cw);
        return cw[CW_MEM_RD];
    endfunction

    function automatic logic cw_mem_wr(input logic [SAM_CW_W-1:0] cw);
        return cw[CW_MEM_WR];
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: strobe/address/data handshake between the controller and the memory responder
interface mem_responder_if #(
    parameter int ADDR_W = mem_responder_pkg::SAM_ADDR_W,
    parameter int DATA_W = mem_responder_pkg::SAM_DATA_W
);
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              wait_;
    logic              protocol_err;

    modport master (output mem_rd, mem_wr, addr, wdata, input rdata, wait_, protocol_err);
    modport slave  (input mem_rd, mem_wr, addr, wdata, output rdata, wait_, protocol_err);
endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_array: word array with synchronous write and asynchronous read
module mem_array #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096
)(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk)
        if (we_i) mem_q[addr_i] <= wdata_i;

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory access driven by control-word strobes, with wait_ handshake
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = SAM_ADDR_W,
    parameter int DATA_W  = SAM_DATA_W,
    parameter int DEPTH   = 2**ADDR_W,
    parameter int LATENCY = 2
)(
    input logic            clk,
    input logic            rst_n,
    mem_responder_if.slave bus
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [DATA_W-1:0]  arr_rdata;
    logic               wr_q, wr_d;
    logic               wait_q, wait_d;
    logic               err_q, err_d;
    logic               req, capture, commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            wait_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign req = bus.mem_rd | bus.mem_wr;

    always_comb begin
        state_d = (state_q == ST_IDLE) ? (req ? ST_BUSY : ST_IDLE) :
                  (state_q == ST_BUSY) ? ((cnt_q == '0) ? ST_DONE : ST_BUSY) : ST_IDLE;
    end

    // Write wins when both strobes arrive together; the collision is remembered in err_q
    always_comb begin
        capture = (state_q == ST_IDLE) && req;
        commit  = (state_q == ST_BUSY) && (cnt_q == '0);
        cnt_d   = capture ? CNT_W'(LATENCY - 1) :
                  ((state_q == ST_BUSY) && (cnt_q != '0)) ? cnt_q - 1'b1 : cnt_q;
        addr_d  = capture ? bus.addr : addr_q;
        wdata_d = capture ? bus.wdata : wdata_q;
        wr_d    = capture ? bus.mem_wr : wr_q;
        rdata_d = (commit && !wr_q) ? arr_rdata : rdata_q;
        err_d   = err_q | (capture & bus.mem_rd & bus.mem_wr);
        wait_d  = (state_d != ST_BUSY);
    end

    mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .we_i    (commit & wr_q),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign bus.rdata        = rdata_q;
    assign bus.wait_        = wait_q;
    assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for LATENCY=2 and LATENCY=1 responders
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    bit          sel = 1'b0;
    logic        rd_s = 1'b0, wr_s = 1'b0;
    logic [11:0] addr_s = '0;
    logic [15:0] wdata_s = '0;
    int          n_pass = 0, n_tot = 0, cyc = 0;
    logic [15:0] ma [int];
    logic [15:0] mb [int];
    logic [15:0] sb [$];
    logic        wt, errt;
    logic [15:0] rdt;

    mem_responder_if #(.ADDR_W(12), .DATA_W(16)) ia ();
    mem_responder_if #(.ADDR_W(12), .DATA_W(16)) ib ();

    mem_responder #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096), .LATENCY(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    mem_responder #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096), .LATENCY(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    assign ia.mem_rd = rd_s & !sel;
    assign ia.mem_wr = wr_s & !sel;
    assign ia.addr   = addr_s;
    assign ia.wdata  = wdata_s;
    assign ib.mem_rd = rd_s & sel;
    assign ib.mem_wr = wr_s & sel;
    assign ib.addr   = addr_s;
    assign ib.wdata  = wdata_s;
    assign wt   = sel ? ib.wait_ : ia.wait_;
    assign rdt  = sel ? ib.rdata : ia.rdata;
    assign errt = sel ? ib.protocol_err : ia.protocol_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic acc(input bit s, input bit r, input bit w, input logic [11:0] a, input logic [15:0] d,
                       input bit hold, input logic [11:0] a2, input int lat, input string tag);
        int n;
        logic [15:0] exp;
        exp = '0;
        sel = s; addr_s = a; wdata_s = d; rd_s = r; wr_s = w;
        if (w) begin
            if (s) mb[int'(a)] = d; else ma[int'(a)] = d;
        end else if (r) sb.push_back(s ? mb[int'(a)] : ma[int'(a)]);
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin rd_s = 1'b0; wr_s = 1'b0; end
        addr_s = a2;
        n = 0;
        while (wt === 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_waitlo"}, n, lat);
        if (r && !w) begin
            exp = sb.pop_front();
            chk({tag, "_rdata"}, rdt, exp);
        end
        @(negedge clk);
        rd_s = 1'b0; wr_s = 1'b0;
        if (r && !w) chk({tag, "_hold"}, rdt, exp);
        if (hold) begin
            @(negedge clk);
            chk({tag, "_noretrig"}, wt, 1'b1);
        end
    endtask

    task automatic b2b(input bit s, input logic [11:0] a, input int period, input logic [15:0] exp, input string tag);
        int n, t1;
        sel = s; addr_s = a; rd_s = 1'b1;
        n = 0;
        while (wt === 1'b1 && n < 40) begin n++; @(negedge clk); end
        t1 = cyc;
        while (wt === 1'b0 && n < 80) begin n++; @(negedge clk); end
        while (wt === 1'b1 && n < 120) begin n++; @(negedge clk); end
        chk({tag, "_period"}, cyc - t1, period);
        rd_s = 1'b0;
        n = 0;
        while (wt === 1'b0 && n < 40) begin n++; @(negedge clk); end
        chk({tag, "_rdata"}, rdt, exp);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wait", wt, 1'b1);
            chk("rst_rdata", rdt, 16'h0000);
            chk("rst_err", errt, 1'b0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_wait", wt, 1'b1);

        acc(0, 0, 1, 12'h010, 16'hBEEF, 0, 12'h010, 2, "wr010");
        acc(0, 1, 0, 12'h010, 16'h0000, 0, 12'h010, 2, "rd010");
        acc(0, 0, 1, 12'h020, 16'h7777, 0, 12'h020, 2, "wr020");
        acc(0, 1, 0, 12'h010, 16'h0000, 1, 12'h020, 2, "rdhold");
        chk("hold_err", errt, 1'b0);
        acc(0, 1, 0, 12'h020, 16'h0000, 0, 12'h020, 2, "rd020");

        acc(0, 1, 1, 12'h005, 16'h1234, 0, 12'h005, 2, "rdwr005");
        chk("err_set", errt, 1'b1);
        acc(0, 1, 0, 12'h005, 16'h0000, 0, 12'h005, 2, "rd005");
        chk("err_sticky", errt, 1'b1);

        acc(0, 0, 1, 12'h030, 16'hAAAA, 0, 12'h030, 2, "pre030");
        acc(0, 1, 0, 12'h010, 16'h0000, 0, 12'h010, 2, "rdpre");
        sel = 1'b0; addr_s = 12'h030; wdata_s = 16'h5555; wr_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("busy_before_rst", wt, 1'b0);
        wr_s = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_wait", wt, 1'b1);
        chk("rstmid_rdata", rdt, 16'h0000);
        chk("rstmid_err", errt, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        acc(0, 1, 0, 12'h030, 16'h0000, 0, 12'h030, 2, "rd030");
        b2b(0, 12'h010, 4, 16'hBEEF, "b2b_l2");

        acc(1, 0, 1, 12'hFFF, 16'h0F0F, 0, 12'hFFF, 1, "wrFFF");
        acc(1, 1, 0, 12'hFFF, 16'h0000, 0, 12'hFFF, 1, "rdFFF");
        acc(1, 0, 1, 12'h000, 16'h3C3C, 0, 12'h000, 1, "wr000");
        acc(1, 1, 0, 12'h000, 16'h0000, 0, 12'h000, 1, "rd000");
        acc(1, 1, 0, 12'hFFF, 16'h0000, 0, 12'hFFF, 1, "rdFFF2");
        b2b(1, 12'hFFF, 3, 16'h0F0F, "b2b_l1");
        chk("b_err", errt, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
